ps2_scan_rx: RTL and testbench
==============================

// Module: ps2_scan_rx
// PURPOSE
//  Receives PS/2 keyboard frames (start, 8 data LSB-first, odd parity, stop) from the pins.
//  Validates each frame and buffers good scan codes in a small FIFO.
//  Sits directly upstream of the key-lookup muxes: downstream logic pops bytes and maps them
//  through a key/value table to ASCII and seven-segment codes.
// PARAMETERS
//  FIFO_DEPTH   8      entries in the scan-code FIFO; power of two, >= 2
//  SYNC_STAGES  3      flip-flops in the ps2_clk/ps2_data synchronisers; >= 2
//  TIMEOUT_CYC  50000  idle clk cycles mid-frame before the bit counter is abandoned
// PORTS
//  clk         in   1  system clock; all logic on its rising edge
//  rst         in   1  synchronous reset, active-high
//  ps2_clk     in   1  raw PS/2 clock pin, asynchronous to clk
//  ps2_data    in   1  raw PS/2 data pin, asynchronous to clk
//  rd_en       in   1  pop request; honoured only when valid=1
//  data        out  8  scan code at the FIFO head; combinational from storage
//  valid       out  1  FIFO non-empty
//  overflow    out  1  sticky; a good frame arrived while the FIFO was full
//  parity_err  out  1  one-cycle pulse; a frame was rejected (start/parity/stop)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; bit counter 0; timeout counter 0.
//  Synchroniser outputs are forced to 1 (idle) on reset.
//  Edge detect: fall = (synced ps2_clk previous cycle == 1) && (current == 0); one clk-cycle pulse.
//  Frame shift: on each fall, shift synced ps2_data into a 10-bit register (start..parity);
//   cnt increments 0..9.
//  Frame end: the fall with cnt==10 samples the stop bit.
//   Good when start==0, stop==1 and ^{data[7:0],parity}==1 (odd).
//   In that cycle cnt returns to 0.
//  Good frame, FIFO not full: push data[7:0]; valid=1 and data shows the byte on the next cycle
//   (latency 1 clk after the detected fall).
//  Good frame, FIFO full: byte dropped; overflow<=1 and stays 1 until rst; FIFO contents untouched.
//  Bad frame: nothing pushed; parity_err=1 for exactly the next cycle; cnt returns to 0.
//  Timeout: while cnt!=0, an idle counter increments each cycle without a fall and clears on any fall.
//   Reaching TIMEOUT_CYC sets cnt=0 and discards the partial frame, with no error pulse.
//  FIFO: read/write pointers carry one extra wrap bit.
//   empty = pointers equal; full = indices equal with wrap bits different.
//   Pointers wrap modulo 2*FIFO_DEPTH.
//  Pop: rd_en && valid advances rptr on this edge; data shows the next entry on the next cycle.
//   rd_en while empty is ignored.
//  Simultaneous push and pop: both take effect; occupancy is unchanged.
//   When full, the pop frees a slot in the same cycle, so the push succeeds and overflow is not set.
//  Reset mid-frame or mid-burst: everything returns to reset state on the next edge;
//   the partial frame is lost.
// STRUCTURE
//  Shared package/header: PS2_FRAME_BITS=11, SCAN_BREAK=8'hF0, SCAN_EXT=8'hE0.
//   Downstream decode uses the same constants.
//  One sub-module: ps2_sync_fifo (parameterised depth/width, push/pop/full/empty, wrap-bit pointers).
//  Synchroniser, edge detect, shift/count and timeout logic stay in the top.
// TESTING
//  Byte 8'h1C, correct parity, one frame:
//   -> valid rises 1 cycle after the 11th fall, data=8'h1C; rd_en=1 for 1 cycle -> valid=0.
//  Frame with flipped parity bit:
//   -> parity_err high exactly 1 cycle, valid stays 0; the next good frame 8'h32 is accepted.
//  9 good frames 8'h01..8'h09 with no pops (FIFO_DEPTH=8):
//   -> overflow=1 after the 9th; pops return 01..08 in order, then valid=0.
//  FIFO full, rd_en asserted in the same cycle as the 9th frame's push:
//   -> overflow stays 0; pops return 02..09.
//  4 bits of a frame, then idle TIMEOUT_CYC cycles, then full frame 8'hF0:
//   -> no error, data=8'hF0 received.
//  rst pulsed after 6 bits of a frame:
//   -> outputs 0; a following good frame 8'hE0 is received correctly.

Source files
------------

// File: rtl/ps2_scan_rx_pkg.sv
// Shared PS/2 constants and frame-check helper; downstream key decode imports the same package.
package ps2_scan_rx_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  SCAN_BREAK     = 8'hF0;
  localparam logic [7:0]  SCAN_EXT       = 8'hE0;

  typedef logic [7:0] scan_code_t;

  // shift holds {parity, data[7:0], start} with start in bit 0
  function automatic logic frame_good(input logic [9:0] shift, input logic stop);
    return !shift[0] && stop && (^shift[9:1]);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop on a full FIFO frees room for a same-cycle push.
module ps2_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver: pin synchronisers, frame validation and a scan-code FIFO.
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       parity_err
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]  CNT_LAST = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic [9:0]             r_shift;
  logic [3:0]             r_cnt;
  logic [TW-1:0]          r_idle;
  logic                   r_parity_err;
  logic                   r_overflow;

  logic       w_clk_s;
  logic       w_dat_s;
  logic       w_fall;
  logic       w_frame_end;
  logic       w_good;
  logic       w_push;
  logic       w_drop;
  logic       w_empty;
  logic       w_full;
  scan_code_t w_rdata;

  // Idle-high synchronisers so a reset never manufactures a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
  assign w_fall      = r_clk_prev && !w_clk_s;
  assign w_frame_end = w_fall && (r_cnt == CNT_LAST);
  assign w_good      = frame_good(r_shift, w_dat_s);
  assign w_push      = w_frame_end && w_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_idle       <= '0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_frame_end && !w_good;
      if (w_drop) r_overflow <= 1'b1;
      if (w_fall) begin
        r_idle <= '0;
        if (w_frame_end) begin
          r_cnt <= '0;
        end else begin
          r_cnt   <= r_cnt + 4'd1;
          r_shift <= {w_dat_s, r_shift[9:1]};
        end
      end else if (r_cnt != '0) begin
        // Abandon a stalled partial frame silently
        if (r_idle == TW'(TIMEOUT_CYC - 1)) begin
          r_cnt  <= '0;
          r_idle <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (r_shift[8:1]),
    .i_pop   (rd_en),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign data       = w_rdata;
  assign valid      = !w_empty;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_scan_rx;
  import ps2_scan_rx_pkg::*;

  localparam int unsigned TO  = 1000;
  localparam int unsigned LAT = 4;  // pin fall -> valid/parity_err: 3 sync stages + 1 register

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       parity_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ps2_scan_rx #(
    .FIFO_DEPTH  (8),
    .SYNC_STAGES (3),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .data       (data),
    .valid      (valid),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always @(negedge clk) if (parity_err) n_err++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
    logic par;
    par = (~^b) ^ flip;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Leaves ps2_clk low right after the last driven fall
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(10);
      ps2_clk = 1'b0;
      if (i != n - 1) begin
        cyc(20);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic release_clk;
    cyc(20);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    release_clk();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq({tag, " valid"}, 32'(valid), 32'd1);
    check_eq({tag, " data"}, 32'(data), 32'(exp));
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int e0;
    cyc(5);
    rst = 1'b0;
    cyc(2);
    check_eq("rst valid", 32'(valid), 32'd0);
    check_eq("rst overflow", 32'(overflow), 32'd0);
    check_eq("rst parity_err", 32'(parity_err), 32'd0);
    check_eq("rst data", 32'(data), 32'd0);

    // Single good frame, exact latency
    send_bits(mk_frame(8'h1C, 1'b0), 11);
    cyc(LAT - 1);
    check_eq("t1 valid early", 32'(valid), 32'd0);
    cyc(1);
    check_eq("t1 valid", 32'(valid), 32'd1);
    check_eq("t1 data", 32'(data), 32'h1C);
    release_clk();
    pop_check("t1 pop", 8'h1C);
    check_eq("t1 empty", 32'(valid), 32'd0);

    // Bad parity: one-cycle error pulse, then a good frame
    send_bits(mk_frame(8'h55, 1'b1), 11);
    cyc(LAT - 1);
    check_eq("t2 perr early", 32'(parity_err), 32'd0);
    cyc(1);
    check_eq("t2 perr", 32'(parity_err), 32'd1);
    cyc(1);
    check_eq("t2 perr end", 32'(parity_err), 32'd0);
    check_eq("t2 no push", 32'(valid), 32'd0);
    release_clk();
    send_frame(8'h32);
    pop_check("t2 pop", 8'h32);
    check_eq("t2 empty", 32'(valid), 32'd0);

    // Overflow with 9 frames into 8 entries
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i));
      if (i == 8) check_eq("t3 ovf at 8", 32'(overflow), 32'd0);
    end
    check_eq("t3 ovf at 9", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) pop_check("t3 pop", 8'(i));
    check_eq("t3 empty", 32'(valid), 32'd0);
    check_eq("t3 ovf sticky", 32'(overflow), 32'd1);

    // Reset mid-frame
    send_frame(8'h77);
    check_eq("t6 pre valid", 32'(valid), 32'd1);
    send_bits(mk_frame(8'h12, 1'b0), 6);
    release_clk();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_eq("t6 valid", 32'(valid), 32'd0);
    check_eq("t6 overflow", 32'(overflow), 32'd0);
    check_eq("t6 parity_err", 32'(parity_err), 32'd0);
    check_eq("t6 data", 32'(data), 32'd0);
    send_frame(SCAN_EXT);
    pop_check("t6 pop", 8'hE0);
    check_eq("t6 empty", 32'(valid), 32'd0);

    // Full FIFO, pop coincides with the 9th push
    for (int i = 1; i <= 8; i++) send_frame(8'(i));
    send_bits(mk_frame(8'h09, 1'b0), 11);
    cyc(LAT - 1);
    check_eq("t4 head", 32'(data), 32'h01);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    release_clk();
    check_eq("t4 overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 9; i++) pop_check("t4 pop", 8'(i));
    check_eq("t4 empty", 32'(valid), 32'd0);

    // Partial frame abandoned by timeout
    e0 = n_err;
    send_bits(mk_frame(8'hAB, 1'b0), 4);
    release_clk();
    cyc(TO + 20);
    send_frame(SCAN_BREAK);
    check_eq("t5 no err", 32'(n_err - e0), 32'd0);
    pop_check("t5 pop", 8'hF0);
    check_eq("t5 empty", 32'(valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
